// File: rtl/id_operand_unit_pkg.sv
// Shared constants and types for the ID operand-fetch slice: default widths,
// stall-bus bit positions, forwarding-source indices and the ID/EX update action.
package id_operand_unit_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Bit positions on the pipeline stall bus that drive stall_id / stall_ex.
  localparam int STALL_ID_BIT = 0;
  localparam int STALL_EX_BIT = 1;

  // Forwarding source order; lower index is younger and wins.
  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  typedef enum logic [1:0] {
    IDEX_HOLD,
    IDEX_CLEAR,
    IDEX_BUBBLE,
    IDEX_LOAD
  } idex_op_e;

endpackage

// File: rtl/id_fwd_port_sel.sv
// One read port's forwarding select: youngest matching producer wins, otherwise
// the register-file value; flags a hazard when the winner's result is not ready.
module id_fwd_port_sel
  import id_operand_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_FWD = 3
) (
  input  logic                             in_valid,
  input  logic                             rd_used,
  input  logic [ADDR_W-1:0]                rd_addr,
  input  logic [DATA_W-1:0]                rf_rdata,
  input  logic [NUM_FWD-1:0]               fwd_we,
  input  logic [NUM_FWD-1:0]               fwd_ready,
  input  logic [NUM_FWD-1:0][ADDR_W-1:0]   fwd_waddr,
  input  logic [NUM_FWD-1:0][DATA_W-1:0]   fwd_wdata,
  output logic [DATA_W-1:0]                rdata,
  output logic                             hazard
);

  logic [DATA_W-1:0] sel_data;
  logic              sel_ready;

  // Walk oldest to youngest so the lowest-index match is the last to assign.
  always_comb begin
    sel_data  = rf_rdata;
    sel_ready = 1'b1;
    for (int j = NUM_FWD - 1; j >= 0; j--) begin
      if (fwd_we[j] && (fwd_waddr[j] == rd_addr) && (rd_addr != '0)) begin
        sel_data  = fwd_wdata[j];
        sel_ready = fwd_ready[j];
      end
    end
    hazard = in_valid && rd_used && !sel_ready;
    rdata  = in_valid ? sel_data : '0;
  end

endmodule

// File: rtl/id_operand_unit.sv
// ID operand fetch: register file with write-through, NUM_FWD-source forwarding
// with load-use stall detection, and the ID/EX operand register.
module id_operand_unit
  import id_operand_unit_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = 2,
  parameter int NUM_FWD = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      stall_id,
  input  logic                      stall_ex,
  input  logic                      in_valid,
  input  logic [NUM_RD*ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD-1:0]         rd_used,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic                      wb_we,
  input  logic [ADDR_W-1:0]         wb_waddr,
  input  logic [DATA_W-1:0]         wb_wdata,
  output logic                      stallreq,
  output logic [NUM_RD*DATA_W-1:0]  comb_rdata,
  output logic                      out_valid,
  output logic [NUM_RD*DATA_W-1:0]  out_rdata,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_RD-1:0][ADDR_W-1:0]  ra;
  logic [NUM_FWD-1:0][ADDR_W-1:0] fwa;
  logic [NUM_FWD-1:0][DATA_W-1:0] fwd;
  logic [NUM_RD-1:0][DATA_W-1:0]  rf_rd;
  logic [NUM_RD-1:0][DATA_W-1:0]  comb_a;
  logic [NUM_RD-1:0]              hazard;

  assign ra  = rd_addr;
  assign fwa = fwd_waddr;
  assign fwd = fwd_wdata;

  logic [DATA_W-1:0] rf [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wb_we && (wb_waddr != '0)) rf[wb_waddr] <= wb_wdata;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_port
    // Entry 0 is never written, so the zero guard is what makes it read 0.
    assign rf_rd[k] = (ra[k] == '0)                     ? '0       :
                      (wb_we && (wb_waddr == ra[k]))    ? wb_wdata :
                                                          rf[ra[k]];
    id_fwd_port_sel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_FWD(NUM_FWD)
    ) u_sel (
      .in_valid (in_valid),
      .rd_used  (rd_used[k]),
      .rd_addr  (ra[k]),
      .rf_rdata (rf_rd[k]),
      .fwd_we   (fwd_we),
      .fwd_ready(fwd_ready),
      .fwd_waddr(fwa),
      .fwd_wdata(fwd),
      .rdata    (comb_a[k]),
      .hazard   (hazard[k])
    );
  end

  assign stallreq   = |hazard;
  assign comb_rdata = comb_a;

  idex_op_e idex_op;
  logic     cap_vld;

  // A stalled operand is never captured, even if ID was not told to hold.
  assign cap_vld = in_valid && !stallreq;

  always_comb begin
    idex_op = IDEX_HOLD;
    if (rst || flush)               idex_op = IDEX_CLEAR;
    else if (stall_id && !stall_ex) idex_op = IDEX_BUBBLE;
    else if (!stall_id)             idex_op = IDEX_LOAD;
  end

  always_ff @(posedge clk) begin
    case (idex_op)
      IDEX_CLEAR, IDEX_BUBBLE: begin
        out_valid <= 1'b0;
        out_rdata <= '0;
      end
      IDEX_LOAD: begin
        out_valid <= cap_vld;
        out_rdata <= cap_vld ? comb_rdata : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                            stall_cnt <= '0;
    else if (stallreq && ~&stall_cnt)   stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_id_operand_unit.sv
// Bench for id_operand_unit: directed scenarios with literal expectations, then
// random traffic checked every cycle against a behavioural model.
module tb_id_operand_unit;

  localparam int DW = 32, AW = 5, NR = 2, NF = 3, CW = 2;

  logic             clk = 1'b0;
  logic             rst, flush, stall_id, stall_ex, in_valid;
  logic [NR*AW-1:0] rd_addr;
  logic [NR-1:0]    rd_used;
  logic [NF-1:0]    fwd_we, fwd_ready;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;
  logic             wb_we;
  logic [AW-1:0]    wb_waddr;
  logic [DW-1:0]    wb_wdata;
  logic             stallreq, out_valid;
  logic [NR*DW-1:0] comb_rdata, out_rdata;
  logic [CW-1:0]    stall_cnt;

  id_operand_unit #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_FWD(NF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
    .in_valid(in_valid), .rd_addr(rd_addr), .rd_used(rd_used),
    .fwd_we(fwd_we), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata), .fwd_ready(fwd_ready),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .stallreq(stallreq), .comb_rdata(comb_rdata), .out_valid(out_valid),
    .out_rdata(out_rdata), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model state
  logic [DW-1:0]    m_rf [2**AW];
  logic             m_valid = 1'b0;
  logic [NR*DW-1:0] m_rdata = '0;
  logic [CW-1:0]    m_cnt   = '0;

  function automatic void mdl_port(input int k, output logic [DW-1:0] d, output logic hz);
    logic [AW-1:0] a;
    int win;
    a   = rd_addr[k*AW +: AW];
    win = -1;
    hz  = 1'b0;
    for (int j = 0; j < NF; j++)
      if (win < 0 && fwd_we[j] && fwd_waddr[j*AW +: AW] == a && a != 0) win = j;
    if (a == 0) d = '0;
    else if (win >= 0) begin
      d  = fwd_wdata[win*DW +: DW];
      hz = !fwd_ready[win] && rd_used[k] && in_valid;
    end
    else if (wb_we && wb_waddr == a) d = wb_wdata;
    else d = m_rf[a];
    if (!in_valid) d = '0;
  endfunction

  always @(posedge clk) begin
    logic [DW-1:0]    d;
    logic             hz, any;
    logic [NR*DW-1:0] ed;
    any = 1'b0;
    for (int k = 0; k < NR; k++) begin
      mdl_port(k, d, hz);
      any = any | hz;
      ed[k*DW +: DW] = d;
    end
    if (rst) m_cnt = '0;
    else if (any && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    if (rst || flush) begin m_valid = 1'b0; m_rdata = '0; end
    else if (stall_id && !stall_ex) begin m_valid = 1'b0; m_rdata = '0; end
    else if (!stall_id) begin
      m_valid = in_valid && !any;
      m_rdata = m_valid ? ed : '0;
    end
    if (wb_we && wb_waddr != 0) m_rf[wb_waddr] = wb_wdata;
  end

  always @(negedge clk) begin
    logic [DW-1:0]    d;
    logic             hz, any;
    logic [NR*DW-1:0] ed;
    if (chk_en) begin
      any = 1'b0;
      for (int k = 0; k < NR; k++) begin
        mdl_port(k, d, hz);
        any = any | hz;
        ed[k*DW +: DW] = d;
      end
      chk("m_stallreq", {63'b0, stallreq}, {63'b0, any});
      if (!any) chk("m_comb_rdata", comb_rdata, ed);
      chk("m_out_valid", {63'b0, out_valid}, {63'b0, m_valid});
      chk("m_out_rdata", out_rdata, m_rdata);
      chk("m_stall_cnt", {62'b0, stall_cnt}, {62'b0, m_cnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; stall_id = 0; stall_ex = 0; in_valid = 0;
    rd_addr = '0; rd_used = '0; fwd_we = '0; fwd_ready = '0;
    fwd_waddr = '0; fwd_wdata = '0; wb_we = 0; wb_waddr = '0; wb_wdata = '0;
  endtask

  task automatic set_fwd(input int j, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rdy);
    fwd_we[j] = we;
    fwd_waddr[j*AW +: AW] = a;
    fwd_wdata[j*DW +: DW] = d;
    fwd_ready[j] = rdy;
  endtask

  initial begin
    for (int r = 0; r < 2**AW; r++) m_rf[r] = '0;
    idle();
    rst = 1;
    tick(); tick();
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out_rdata", out_rdata, 64'd0);
    chk("rst_stall_cnt", {62'b0, stall_cnt}, 64'd0);
    rst = 0;
    chk_en = 1'b1;

    for (int r = 1; r < 2**AW; r++) begin
      wb_we = 1; wb_waddr = AW'(r); wb_wdata = $urandom;
      tick();
    end

    // write-through
    wb_we = 1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
    in_valid = 1; rd_addr = {5'd0, 5'd5}; rd_used = 2'b11;
    #2 chk("wt_comb0", {32'b0, comb_rdata[31:0]}, 64'hDEADBEEF);
    tick();
    wb_we = 0;
    chk("wt_out_rdata0", {32'b0, out_rdata[31:0]}, 64'hDEADBEEF);
    chk("wt_out_valid", {63'b0, out_valid}, 64'd1);

    // priority
    set_fwd(0, 1, 3, 32'h11, 1);
    set_fwd(1, 1, 3, 32'h22, 1);
    rd_addr = {5'd3, 5'd5};
    #2 chk("pri_young", {32'b0, comb_rdata[63:32]}, 64'h11);
    chk("pri_stallreq", {63'b0, stallreq}, 64'd0);
    fwd_we = 3'b010;
    #2 chk("pri_old", {32'b0, comb_rdata[63:32]}, 64'h22);
    tick();

    // load-use
    fwd_we = '0;
    set_fwd(0, 1, 7, 32'h77, 0);
    rd_addr = {5'd3, 5'd7}; rd_used = 2'b01; stall_id = 1; stall_ex = 0;
    #2 chk("lu_stallreq", {63'b0, stallreq}, 64'd1);
    tick();
    chk("lu_stall_cnt", {62'b0, stall_cnt}, 64'd1);
    chk("lu_bubble", {63'b0, out_valid}, 64'd0);
    rd_used = 2'b10;
    #2 chk("lu_unused", {63'b0, stallreq}, 64'd0);
    tick();

    // register 0
    stall_id = 0;
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'hFFFF;
    set_fwd(0, 1, 0, 32'h99, 0);
    rd_addr = '0; rd_used = 2'b11;
    #2 chk("r0_comb", comb_rdata, 64'd0);
    chk("r0_stallreq", {63'b0, stallreq}, 64'd0);
    tick();
    wb_we = 0; fwd_we = '0;

    // pipeline control
    rd_addr = {5'd0, 5'd5};
    tick();
    chk("pc_load_valid", {63'b0, out_valid}, 64'd1);
    chk("pc_load_data", {32'b0, out_rdata[31:0]}, 64'hDEADBEEF);
    stall_id = 1; stall_ex = 1; rd_addr = {5'd0, 5'd4};
    tick();
    chk("pc_hold_data", {32'b0, out_rdata[31:0]}, 64'hDEADBEEF);
    chk("pc_hold_valid", {63'b0, out_valid}, 64'd1);
    stall_ex = 0;
    tick();
    chk("pc_bubble_valid", {63'b0, out_valid}, 64'd0);
    chk("pc_bubble_data", out_rdata, 64'd0);
    stall_id = 0; flush = 1; rd_addr = {5'd0, 5'd5};
    tick();
    chk("pc_flush_valid", {63'b0, out_valid}, 64'd0);
    flush = 0;

    // saturation and reset
    rst = 1;
    tick();
    rst = 0;
    set_fwd(0, 1, 7, 32'h77, 0);
    rd_addr = {5'd0, 5'd7}; rd_used = 2'b01; in_valid = 1; stall_id = 1; stall_ex = 1;
    tick(); tick();
    chk("sat_cnt2", {62'b0, stall_cnt}, 64'd2);
    tick(); tick(); tick();
    chk("sat_cnt3", {62'b0, stall_cnt}, 64'd3);
    rst = 1;
    tick();
    chk("sat_rst_cnt", {62'b0, stall_cnt}, 64'd0);
    chk("sat_rst_valid", {63'b0, out_valid}, 64'd0);
    rst = 0;
    #2 chk("rst_recompute", {63'b0, stallreq}, 64'd1);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = (i % 250) == 249;
      flush    = ($urandom_range(15) == 0);
      stall_id = ($urandom_range(2) == 0);
      stall_ex = ($urandom_range(3) == 0);
      in_valid = ($urandom_range(3) != 0);
      for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(7));
      rd_used  = NR'($urandom);
      for (int j = 0; j < NF; j++)
        set_fwd(j, 1'($urandom), AW'($urandom_range(7)), $urandom, $urandom_range(2) != 0);
      wb_we    = 1'($urandom);
      wb_waddr = AW'($urandom_range(7));
      wb_wdata = $urandom;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
